pong_game_ctrl: RTL



---
 rtl/pong_pkg.sv | 33 +++
 rtl/pong_game_ctrl_paddle.sv | 39 +++
 rtl/pong_game_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared screen geometry, game constants and FSM encoding for the Pong
// sequencer and the VGA renderer.
package pong_pkg;

    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] PADDLE_H     = 10'd64;
    localparam logic [9:0] PADDLE_W     = 10'd8;
    localparam logic [9:0] PADDLE_X1    = 10'd16;
    localparam logic [9:0] PADDLE_X2    = 10'd616;
    localparam logic [9:0] BALL_SIZE    = 10'd8;
    localparam logic [9:0] PADDLE_SPEED = 10'd4;
    localparam logic [9:0] BALL_SPEED   = 10'd2;
    localparam logic [3:0] WIN_SCORE    = 4'd9;
    localparam logic [5:0] SERVE_FRAMES = 6'd60;

    localparam logic [9:0] PADDLE_Y_MAX    = V_ACTIVE - PADDLE_H;
    localparam logic [9:0] PADDLE_Y_CENTER = (V_ACTIVE - PADDLE_H) >> 1;
    localparam logic [9:0] BALL_X_CENTER   = (H_ACTIVE - BALL_SIZE) >> 1;
    localparam logic [9:0] BALL_Y_CENTER   = (V_ACTIVE - BALL_SIZE) >> 1;
    // Ball x positions at which it touches the inner face of each paddle.
    localparam logic [9:0] P1_FACE_X = PADDLE_X1 + PADDLE_W;
    localparam logic [9:0] P2_FACE_X = PADDLE_X2 - BALL_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_e;

endpackage

// File: rtl/pong_game_ctrl_paddle.sv
// One player's paddle: saturating up/down movement once per enabled frame,
// with a recenter request used when a new game starts.
module paddle_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       recenter,
    input  logic       up,
    input  logic       down,
    output logic [9:0] y
);

    logic [9:0] y_q;
    logic [9:0] y_d;

    always_comb begin
        y_d = y_q;
        if (recenter) begin
            y_d = PADDLE_Y_CENTER;
        end else if (en && up && !down) begin
            y_d = (y_q < PADDLE_SPEED) ? 10'd0 : y_q - PADDLE_SPEED;
        end else if (en && down && !up) begin
            y_d = (y_q > PADDLE_Y_MAX - PADDLE_SPEED) ? PADDLE_Y_MAX : y_q + PADDLE_SPEED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= PADDLE_Y_CENTER;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: serve/play/point/game-over flow, ball motion
// with wall and paddle reflection, and scoring. All outputs are registered.
module pong_game_ctrl
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_down,
    input  logic       p2_up,
    input  logic       p2_down,
    output logic [9:0] paddle1_y,
    output logic [9:0] paddle2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] game_state,
    output logic       game_over
);

    game_state_e state_q, state_d;
    logic        start_q, start_d;
    logic [5:0]  serve_cnt_q, serve_cnt_d;
    logic [9:0]  ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic        dx_q, dx_d;            // 1 = moving right
    logic        dy_q, dy_d;            // 1 = moving down
    logic [3:0]  score1_q, score1_d;
    logic [3:0]  score2_q, score2_d;
    logic        p1_scored_q, p1_scored_d;
    logic        game_over_q, game_over_d;

    logic        start_rise;
    logic        paddle_en;
    logic        recenter;
    logic [9:0]  p1_y, p2_y;
    logic        overlap1, overlap2;
    logic [9:0]  step_x, step_y;
    logic        step_dx, step_dy;
    logic        miss_left, miss_right;
    logic [3:0]  score_next;

    assign start_rise = start & ~start_q;
    assign paddle_en  = frame_tick && (state_q == ST_SERVE || state_q == ST_PLAY);

    paddle_ctrl u_paddle1 (
        .clk      (clk),
        .rst      (rst),
        .en       (paddle_en),
        .recenter (recenter),
        .up       (p1_up),
        .down     (p1_down),
        .y        (p1_y)
    );

    paddle_ctrl u_paddle2 (
        .clk      (clk),
        .rst      (rst),
        .en       (paddle_en),
        .recenter (recenter),
        .up       (p2_up),
        .down     (p2_down),
        .y        (p2_y)
    );

    // Collision tests use the paddle rows held before this frame's move.
    assign overlap1 = (ball_y_q + BALL_SIZE > p1_y) && (ball_y_q < p1_y + PADDLE_H);
    assign overlap2 = (ball_y_q + BALL_SIZE > p2_y) && (ball_y_q < p2_y + PADDLE_H);

    always_comb begin
        step_y  = ball_y_q;
        step_dy = dy_q;
        if (!dy_q) begin
            if (ball_y_q < BALL_SPEED) begin
                step_y  = 10'd0;
                step_dy = 1'b1;
            end else begin
                step_y = ball_y_q - BALL_SPEED;
            end
        end else begin
            if (ball_y_q + BALL_SIZE + BALL_SPEED > V_ACTIVE) begin
                step_y  = V_ACTIVE - BALL_SIZE;
                step_dy = 1'b0;
            end else begin
                step_y = ball_y_q + BALL_SPEED;
            end
        end

        step_x     = ball_x_q;
        step_dx    = dx_q;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        if (!dx_q) begin
            if (ball_x_q < BALL_SPEED) begin
                miss_left = 1'b1;
            end else begin
                step_x = ball_x_q - BALL_SPEED;
                if (ball_x_q >= P1_FACE_X && step_x < P1_FACE_X && overlap1) begin
                    step_x  = P1_FACE_X;
                    step_dx = 1'b1;
                end
            end
        end else begin
            if (ball_x_q + BALL_SIZE + BALL_SPEED > H_ACTIVE) begin
                miss_right = 1'b1;
            end else begin
                step_x = ball_x_q + BALL_SPEED;
                if (ball_x_q <= P2_FACE_X && step_x > P2_FACE_X && overlap2) begin
                    step_x  = P2_FACE_X;
                    step_dx = 1'b0;
                end
            end
        end
    end

    assign score_next = (p1_scored_q ? score1_q : score2_q) + 4'd1;

    always_comb begin
        state_d     = state_q;
        start_d     = start;
        serve_cnt_d = serve_cnt_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        p1_scored_d = p1_scored_q;
        recenter    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = SERVE_FRAMES;
                    dx_d        = 1'b1;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    serve_cnt_d = serve_cnt_q - 6'd1;
                    if (serve_cnt_q == 6'd1) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (miss_left || miss_right) begin
                        // Ball stays where it was; the point is settled next cycle.
                        state_d     = ST_POINT;
                        p1_scored_d = miss_right;
                    end else begin
                        ball_x_d = step_x;
                        ball_y_d = step_y;
                        dx_d     = step_dx;
                        dy_d     = step_dy;
                    end
                end
            end
            ST_POINT: begin
                if (p1_scored_q) begin
                    score1_d = score_next;
                end else begin
                    score2_d = score_next;
                end
                if (score_next == WIN_SCORE) begin
                    state_d = ST_GAME_OVER;
                end else begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = SERVE_FRAMES;
                    ball_x_d    = BALL_X_CENTER;
                    ball_y_d    = BALL_Y_CENTER;
                    dx_d        = p1_scored_q;
                end
            end
            ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = SERVE_FRAMES;
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    ball_x_d    = BALL_X_CENTER;
                    ball_y_d    = BALL_Y_CENTER;
                    dx_d        = 1'b1;
                    recenter    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            serve_cnt_q <= 6'd0;
            ball_x_q    <= BALL_X_CENTER;
            ball_y_q    <= BALL_Y_CENTER;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            p1_scored_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            serve_cnt_q <= serve_cnt_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            p1_scored_q <= p1_scored_d;
            game_over_q <= game_over_d;
        end
    end

    assign paddle1_y  = p1_y;
    assign paddle2_y  = p2_y;
    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign game_state = state_q;
    assign game_over  = game_over_q;

endmodule
